// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared constants and types for the pipelined sine/cosine CORDIC slice:
// angle/phase widths, binary-angle landmarks, default start vector,
// core pipeline latency, sideband record and the fold/saturate helpers.
// ---------------------------------------------------------------------------
package cordic_pkg;

   localparam int unsigned ANG_W        = 16;
   localparam int unsigned PHASE_W      = 32;
   localparam int unsigned CORE_LATENCY = 16;

   localparam logic [ANG_W-1:0] ANG_90     = 16'h4000;
   localparam logic [ANG_W-1:0] ANG_180    = 16'h8000;
   localparam logic [ANG_W-1:0] X_INIT_DEF = 16'd19432;

   // Sideband carried alongside the core pipeline
   typedef struct packed {
      logic valid;
      logic negate;
   } sideband_t;

   // Angles in [90, 270) have top two bits 01 or 10
   function automatic logic needs_fold(input logic [ANG_W-1:0] a);
      return a[ANG_W-1] ^ a[ANG_W-2];
   endfunction

   // Two's-complement negate; the most negative code maps to the most positive
   function automatic logic [ANG_W-1:0] sat_neg(input logic [ANG_W-1:0] v);
      logic [ANG_W-1:0] r;
      if (v == ANG_180) r = 16'h7FFF;
      else              r = (~v) + 16'd1;
      return r;
   endfunction

endpackage

// File: rtl/sideband_delay.sv
// ---------------------------------------------------------------------------
// sideband_delay
// Free-running shift register of WIDTH bits and DEPTH stages, used to carry
// per-sample sideband alongside a fixed-latency datapath.
// Ports:
//   clock  in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears every stage
//   i_d    in   WIDTH  value entering stage 0
//   o_q    out  WIDTH  value leaving stage DEPTH-1 (DEPTH cycles later)
// ---------------------------------------------------------------------------
module sideband_delay #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/cordic_phase_feed.sv
// ---------------------------------------------------------------------------
// cordic_phase_feed
// NCO phase accumulator plus quadrant fold feeding a 16-stage sine/cosine
// CORDIC core, and the matching sign-correction stage at the core output.
// Ports:
//   clock, rst_n         clock / async active-low reset
//   enable               advance accumulator and emit one sample
//   phase_inc[31:0]      per-sample increment (2^32 = 360 deg)
//   phase_load           load accumulator (wins over enable, no sample)
//   phase_load_val[31:0] accumulator load value
//   x_start, y_start     core start vector (signed 16)
//   angle                core binary angle (0x4000 = 90 deg)
//   feed_valid           core inputs hold a real sample
//   cos_raw, sin_raw     core outputs (signed 16)
//   cosine, sine         quadrant-corrected outputs
//   out_valid            cosine/sine valid this cycle
// ---------------------------------------------------------------------------
module cordic_phase_feed
   import cordic_pkg::*;
#(
   parameter int unsigned      CORE_LATENCY = cordic_pkg::CORE_LATENCY,
   parameter logic [15:0]      X_INIT       = cordic_pkg::X_INIT_DEF
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [31:0] phase_inc,
   input  logic        phase_load,
   input  logic [31:0] phase_load_val,
   output logic [15:0] x_start,
   output logic [15:0] y_start,
   output logic [15:0] angle,
   output logic        feed_valid,
   input  logic [15:0] cos_raw,
   input  logic [15:0] sin_raw,
   output logic [15:0] cosine,
   output logic [15:0] sine,
   output logic        out_valid
);

   logic [PHASE_W-1:0] r_acc;
   logic [ANG_W-1:0]   r_angle;
   logic [ANG_W-1:0]   r_x;
   logic [ANG_W-1:0]   r_y;
   logic               r_valid;
   logic               r_negate;
   logic [ANG_W-1:0]   r_cos;
   logic [ANG_W-1:0]   r_sin;
   logic               r_out_valid;

   logic               w_sample;
   logic [ANG_W-1:0]   w_a;
   logic               w_fold;
   logic [ANG_W-1:0]   w_angle;
   sideband_t          w_sb_in;
   sideband_t          w_sb_out;

   assign w_sample = enable & ~phase_load;
   assign w_a      = r_acc[PHASE_W-1:PHASE_W-ANG_W];
   assign w_fold   = needs_fold(w_a);
   // Rotating by 180 deg lands in the core's +/-90 range; the result is
   // sign-flipped back at the output using the carried negate flag.
   assign w_angle  = w_fold ? (w_a + ANG_180) : w_a;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)          r_acc <= '0;
      else if (phase_load) r_acc <= phase_load_val;
      else if (enable)     r_acc <= r_acc + phase_inc;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_angle  <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_valid  <= 1'b0;
         r_negate <= 1'b0;
      end else begin
         r_angle  <= w_sample ? w_angle : '0;
         r_x      <= w_sample ? X_INIT  : '0;
         r_y      <= '0;
         r_valid  <= w_sample;
         r_negate <= w_sample & w_fold;
      end
   end

   assign w_sb_in.valid  = r_valid;
   assign w_sb_in.negate = r_negate;

   sideband_delay #(
      .WIDTH ($bits(sideband_t)),
      .DEPTH (CORE_LATENCY)
   ) u_sideband_delay (
      .clock (clock),
      .rst_n (rst_n),
      .i_d   (w_sb_in),
      .o_q   (w_sb_out)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_cos       <= '0;
         r_sin       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_cos       <= w_sb_out.negate ? sat_neg(cos_raw) : cos_raw;
         r_sin       <= w_sb_out.negate ? sat_neg(sin_raw) : sin_raw;
         r_out_valid <= w_sb_out.valid;
      end
   end

   assign angle      = r_angle;
   assign x_start    = r_x;
   assign y_start    = r_y;
   assign feed_valid = r_valid;
   assign cosine     = r_cos;
   assign sine       = r_sin;
   assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_cordic_phase_feed.sv
module tb_cordic_phase_feed;

   logic        clock;
   logic        rst_n;
   logic        enable;
   logic [31:0] phase_inc;
   logic        phase_load;
   logic [31:0] phase_load_val;
   logic [15:0] x_start, y_start, angle;
   logic        feed_valid;
   logic [15:0] cos_raw, sin_raw;
   logic [15:0] cosine, sine;
   logic        out_valid;

   int nvec = 0;
   int nerr = 0;
   logic ovr = 1'b0;

   cordic_phase_feed dut (
      .clock          (clock),
      .rst_n          (rst_n),
      .enable         (enable),
      .phase_inc      (phase_inc),
      .phase_load     (phase_load),
      .phase_load_val (phase_load_val),
      .x_start        (x_start),
      .y_start        (y_start),
      .angle          (angle),
      .feed_valid     (feed_valid),
      .cos_raw        (cos_raw),
      .sin_raw        (sin_raw),
      .cosine         (cosine),
      .sine           (sine),
      .out_valid      (out_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural stand-in for the 16-stage core: amplitude 32000, result
   // appears 16 edges after the inputs are presented.
   logic [15:0] m_cos [16];
   logic [15:0] m_sin [16];

   function automatic logic [15:0] rnd(input real r);
      int v;
      v = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
      return v[15:0];
   endfunction

   always @(posedge clock) begin
      real th;
      th = $itor($signed(angle)) * 3.14159265358979 / 32768.0;
      m_cos[0] <= (x_start == 16'd0) ? 16'd0 : rnd(32000.0 * $cos(th));
      m_sin[0] <= (x_start == 16'd0) ? 16'd0 : rnd(32000.0 * $sin(th));
      for (int i = 1; i < 16; i++) begin
         m_cos[i] <= m_cos[i-1];
         m_sin[i] <= m_sin[i-1];
      end
   end

   assign cos_raw = m_cos[15];
   assign sin_raw = ovr ? 16'h8000 : m_sin[15];

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic drain;
      enable = 1'b0;
      phase_load = 1'b0;
      repeat (20) tick();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      enable = 1'b0;
      phase_inc = '0;
      phase_load = 1'b0;
      phase_load_val = '0;
      repeat (3) tick();
      nvec++;
      if ({feed_valid, angle, x_start, y_start, out_valid, cosine, sine} !== '0) begin
         nerr++;
         $display("FAIL reset_state: fv=%b ang=%h x=%h y=%h ov=%b cos=%h sin=%h required all zero",
                  feed_valid, angle, x_start, y_start, out_valid, cosine, sine);
      end
      @(negedge clock);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_latency;
      int n;
      phase_inc = 32'd0;
      enable = 1'b1;
      tick();
      nvec++;
      if (feed_valid !== 1'b1 || angle !== 16'h0000 || x_start !== 16'd19432 || y_start !== 16'd0) begin
         nerr++;
         $display("FAIL first_feed: fv=%b ang=%h x=%0d y=%0d required 1/0000/19432/0",
                  feed_valid, angle, x_start, y_start);
      end
      n = 1;
      while (out_valid !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      nvec++;
      if (n != 18) begin
         nerr++;
         $display("FAIL latency: out_valid after %0d edges, required 18", n);
      end
      nvec++;
      if (iabs(int'($signed(cosine)) - 32000) > 8 || iabs(int'($signed(sine))) > 8) begin
         nerr++;
         $display("FAIL zero_angle_out: cos=%0d sin=%0d required ~32000/~0",
                  $signed(cosine), $signed(sine));
      end
      drain();
   endtask

   task automatic test_fold;
      logic [31:0] ld   [4] = '{32'h4000_0000, 32'h8000_0000, 32'hBFFF_0000, 32'hC000_0000};
      logic [15:0] eang [4] = '{16'hC000, 16'h0000, 16'h3FFF, 16'hC000};
      int          esin [4] = '{32000, 0, -32000, -32000};
      int          ecos [4] = '{0, -32000, 0, 0};
      phase_inc = 32'd0;
      for (int k = 0; k < 4; k++) begin
         phase_load = 1'b1;
         phase_load_val = ld[k];
         enable = 1'b0;
         tick();
         phase_load = 1'b0;
         enable = 1'b1;
         tick();
         enable = 1'b0;
         nvec++;
         if (angle !== eang[k] || feed_valid !== 1'b1) begin
            nerr++;
            $display("FAIL fold_angle[%0d]: ang=%h fv=%b required %h/1", k, angle, feed_valid, eang[k]);
         end
         repeat (17) tick();
         nvec++;
         if (out_valid !== 1'b1 || iabs(int'($signed(sine)) - esin[k]) > 8 ||
             iabs(int'($signed(cosine)) - ecos[k]) > 8) begin
            nerr++;
            $display("FAIL fold_out[%0d]: ov=%b sin=%0d cos=%0d required 1/%0d/%0d",
                     k, out_valid, $signed(sine), $signed(cosine), esin[k], ecos[k]);
         end
      end
      drain();
   endtask

   task automatic test_wrap;
      logic [15:0] ea [3] = '{16'hFFFF, 16'h0001, 16'h0003};
      phase_load = 1'b1;
      phase_load_val = 32'hFFFF_0000;
      tick();
      phase_load = 1'b0;
      phase_inc = 32'h0002_0000;
      enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         nvec++;
         if (angle !== ea[k]) begin
            nerr++;
            $display("FAIL wrap_angle[%0d]: ang=%h required %h", k, angle, ea[k]);
         end
      end
      enable = 1'b0;
      repeat (15) tick();
      nvec++;
      if (out_valid !== 1'b1 || iabs(int'($signed(cosine)) - 32000) > 8) begin
         nerr++;
         $display("FAIL wrap_no_negate: ov=%b cos=%0d required 1/~32000", out_valid, $signed(cosine));
      end
      phase_inc = 32'd0;
      drain();
   endtask

   task automatic test_load_gap;
      logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic ov [25];
      phase_inc = 32'd0;
      phase_load = 1'b1;
      phase_load_val = 32'h1234_0000;
      enable = 1'b1;
      tick();
      phase_load = 1'b0;
      nvec++;
      if (feed_valid !== 1'b0) begin
         nerr++;
         $display("FAIL load_wins: fv=%b required 0", feed_valid);
      end
      for (int k = 0; k < 25; k++) begin
         enable = (k < 4) ? pat[k] : 1'b0;
         tick();
         ov[k] = out_valid;
         if (k == 0) begin
            nvec++;
            if (angle !== 16'h1234) begin
               nerr++;
               $display("FAIL load_value: ang=%h required 1234", angle);
            end
         end
      end
      nvec++;
      if ({ov[16], ov[17], ov[18], ov[19], ov[20], ov[21]} !== 6'b010110) begin
         nerr++;
         $display("FAIL gap_pattern: ov[16..21]=%b%b%b%b%b%b required 010110",
                  ov[16], ov[17], ov[18], ov[19], ov[20], ov[21]);
      end
      drain();
   endtask

   task automatic test_reset_mid;
      int cnt;
      enable = 1'b1;
      repeat (10) tick();
      #2;
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({feed_valid, angle, x_start, y_start, out_valid, cosine, sine} !== '0) begin
         nerr++;
         $display("FAIL async_reset: fv=%b ang=%h x=%h ov=%b cos=%h sin=%h required all zero",
                  feed_valid, angle, x_start, out_valid, cosine, sine);
      end
      enable = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      cnt = 0;
      repeat (20) begin
         tick();
         if (out_valid === 1'b1) cnt++;
      end
      nvec++;
      if (cnt != 0) begin
         nerr++;
         $display("FAIL reset_flush: %0d stale out_valid, required 0", cnt);
      end
   endtask

   task automatic test_saturation;
      phase_inc = 32'd0;
      ovr = 1'b1;
      phase_load = 1'b1;
      phase_load_val = 32'h8000_0000;
      tick();
      phase_load = 1'b0;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      repeat (17) tick();
      nvec++;
      if (out_valid !== 1'b1 || sine !== 16'h7FFF || iabs(int'($signed(cosine)) + 32000) > 8) begin
         nerr++;
         $display("FAIL sat_negate: ov=%b sin=%h cos=%0d required 1/7fff/~-32000",
                  out_valid, sine, $signed(cosine));
      end
      phase_load = 1'b1;
      phase_load_val = 32'h0000_0000;
      tick();
      phase_load = 1'b0;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      repeat (17) tick();
      nvec++;
      if (out_valid !== 1'b1 || sine !== 16'h8000) begin
         nerr++;
         $display("FAIL sat_passthru: ov=%b sin=%h required 1/8000", out_valid, sine);
      end
      ovr = 1'b0;
      drain();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fold();
      test_wrap();
      test_load_gap();
      test_reset_mid();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/cordic_phase_feed.md
# cordic_phase_feed

Upstream feed and downstream sign-fix stage for the 16-stage pipelined sine/cosine CORDIC core. It runs a 32-bit phase accumulator (NCO) and folds each sample angle into the core's ±90° convergence range. It drives the core's `x_start`, `y_start` and `angle` inputs and carries a valid/negate sideband alongside the core pipeline. At the core output it applies the quadrant correction and emits aligned, valid-qualified `sine`/`cosine`.

## Interface
Parameters:
- `CORE_LATENCY`, default 16: cycles from core input register to core output.
- `X_INIT`, default 16'd19432: gain-compensated start vector (0.60725 × 32000), giving an output amplitude of about 32000.

Ports (clock and reset first):
- `clock`  in  1  single clock domain, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  advance the accumulator and emit one sample this cycle.
- `phase_inc`  in  32  per-sample phase increment (2^32 = 360°).
- `phase_load`  in  1  load the accumulator.
- `phase_load_val`  in  32  value to load.
- `x_start`  out  16  signed, to the core.
- `y_start`  out  16  signed, to the core.
- `angle`  out  16  signed binary angle, to the core (0x4000 = 90°).
- `feed_valid`  out  1  core inputs hold a real sample.
- `cos_raw`  in  16  signed core output `cosine`.
- `sin_raw`  in  16  signed core output `sine`.
- `cosine`  out  16  corrected signed output.
- `sine`  out  16  corrected signed output.
- `out_valid`  out  1  `sine`/`cosine` are valid this cycle.

## Operation
- **Accumulator `acc[31:0]`:**
  - `phase_load` = 1: `acc <= phase_load_val`, and no sample is emitted. Load wins over `enable`.
  - Else if `enable` = 1: `acc <= acc + phase_inc`, modulo 2^32 (wrap is silent and intended).
  - Else: `acc` holds.
- **Sampling.** A sample uses the current (pre-update) `acc[31:16]` as the raw angle `a`.
- **Fold.** Applied when `a[15:14]` is 01 or 10, i.e. [90°, 270°):
  - Folded angle = `a + 16'h8000`; negate flag = 1.
  - Otherwise angle = `a`; negate flag = 0.
- **Feed register**, updated every cycle:
  - `angle <=` folded angle.
  - `x_start <= X_INIT`, `y_start <= 0` when a sample is emitted.
  - `feed_valid <=` (enable & ~phase_load).
  - When no sample is emitted, `angle`, `x_start`, `y_start` are driven to 0.
- **Sideband delay line.** Depth `CORE_LATENCY` shift register of {valid, negate}, shifting every cycle. It is not stalled: the core is free-running.
- **Output register:**
  - If delayed negate = 1: `cosine <= sat(-cos_raw)`, `sine <= sat(-sin_raw)`. `sat` maps -32768 to +32767.
  - Otherwise the raw values pass through.
  - `out_valid <=` delayed valid.
  - Data registers update regardless of valid; consumers qualify with `out_valid`.

## Timing
- Reset (async assert, sync release): `acc`, `angle`, `x_start`, `y_start`, `feed_valid`, the whole delay line, `cosine`, `sine` and `out_valid` all go to 0.
- `enable` sampled at edge t gives `feed_valid` = 1 after edge t.
- The matching core result is present after edge t+CORE_LATENCY. `out_valid` = 1 with corrected data after edge t+CORE_LATENCY+1. Total latency is 18 cycles with defaults.
- Throughput is one sample per cycle. Gaps in `enable` propagate as `out_valid` gaps in the same positions.
- Reset mid-stream flushes all in-flight valids; no stale `out_valid` appears after release.
- `phase_load` mid-stream does not disturb samples already in flight.
- Fold boundaries:
  - 0x3FFF: not folded.
  - 0x4000: becomes 0xC000, negated.
  - 0x8000: becomes 0x0000, negated.
  - 0xBFFF: folded.
  - 0xC000: not folded.

## Structure
- Shared package `cordic_pkg`:
  - Angle width 16 and phase width 32.
  - `ANG_90` = 16'h4000 and `ANG_180` = 16'h8000.
  - Default `X_INIT`.
  - The `CORE_LATENCY` constant, also used by the core wrapper.
- One natural sub-module, `sideband_delay`: parameterised width/depth shift register with async reset, used here for {valid, negate}.
- The fold and saturate logic stay inline.

## Test plan
1. **Reset release, `phase_inc` = 0, `enable` = 1:**
   - `feed_valid` rises 1 cycle later, with `angle` = 0 and `x_start` = 19432.
   - `out_valid` rises exactly 18 cycles after the first enable; `cosine` ≈ 32000 (±8), `sine` ≈ 0.
2. **Fold boundaries.** Load `acc` = 0x4000_0000, 0x8000_0000, 0xBFFF_0000, 0xC000_0000 in turn, each with `phase_inc` = 0:
   - `angle`/negate is C000/1, 0000/1, 3FFF/1, C000/0 respectively.
   - Outputs: sin ≈ +32000, cos ≈ -32000, sin ≈ -32000, sin ≈ -32000.
3. **Wrap.** `acc` = 0xFFFF_0000, `phase_inc` = 0x0002_0000, two enables:
   - Sampled angles are 0xFFFF then 0x0001.
   - `acc` ends at 0x0003_0000; no negate.
4. **Load vs enable and gaps.** `phase_load` and `enable` both high in one cycle:
   - No `feed_valid` that cycle; the next sample uses `phase_load_val`.
   - An `enable` pattern 1,0,1,1 reproduces `out_valid` 1,0,1,1 eighteen cycles later.
5. **Reset mid-stream.** Assert `rst_n` = 0 asynchronously with 10 samples in flight:
   - All outputs are 0 immediately.
   - No `out_valid` for 18 cycles after release without new enables.
6. **Saturation.** Force `sin_raw` = -32768 with negate = 1 → `sine` = +32767.
